button_event_counter: RTL

Multi-channel, parametrised button event counter that replaces the derived-slow-clock counter style with a fully single-clock design. Each channel synchronises a raw button input, debounces it with a cycle-accurate stability counter, and emits a one-cycle press pulse. Each channel also maintains an up/down event count with a selectable wrap or saturate policy. It sits between board push-buttons and NPU control/debug logic: step, mode-select and test-pattern selection.

---
 rtl/button_event_counter.sv | 99 +++++++++
 1 files changed

// File: rtl/button_event_counter.sv
// Multi-channel button event counter: per-channel synchroniser, cycle-accurate debounce,
// press strobe and up/down event counter with wrap or saturate policy, all on one clock.
module button_event_counter #(
    parameter int N_CH     = 4,
    parameter int CNT_W    = 32,
    parameter int DEB_CYC  = 240_000,
    parameter bit SATURATE = 1'b0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [N_CH-1:0]         press,
    input  logic [N_CH-1:0]         dir,
    input  logic [N_CH-1:0]         clear,
    input  logic                    en,
    output logic [N_CH*CNT_W-1:0]   count,
    output logic [N_CH-1:0]         press_pulse,
    output logic [N_CH-1:0]         limit
);

    localparam int               DEB_W    = $clog2(DEB_CYC);
    localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_CYC - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    genvar gi;
    generate
        for (gi = 0; gi < N_CH; gi++) begin : g_ch
            logic             sync1_reg;
            logic             sync_reg;
            logic             level_reg;
            logic [DEB_W-1:0] deb_cnt_reg;
            logic [CNT_W-1:0] count_reg;
            logic             pulse_reg;
            logic             limit_reg;
            logic             accept;
            logic             event_hit;
            logic [CNT_W-1:0] count_next;
            logic             limit_next;

            // New level accepted once sync has differed from it for DEB_CYC consecutive edges.
            assign accept    = (sync_reg != level_reg) && (deb_cnt_reg == DEB_LAST);
            assign event_hit = accept && sync_reg;

            always_comb begin
                count_next = count_reg;
                limit_next = 1'b0;
                if (clear[gi]) begin
                    count_next = '0;
                end else if (event_hit && en) begin
                    if (!dir[gi]) begin
                        if (count_reg == CNT_MAX) begin
                            limit_next = 1'b1;
                            count_next = SATURATE ? count_reg : '0;
                        end else begin
                            count_next = count_reg + CNT_W'(1);
                        end
                    end else begin
                        if (count_reg == '0) begin
                            limit_next = 1'b1;
                            count_next = SATURATE ? count_reg : CNT_MAX;
                        end else begin
                            count_next = count_reg - CNT_W'(1);
                        end
                    end
                end
            end

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    sync1_reg   <= 1'b0;
                    sync_reg    <= 1'b0;
                    level_reg   <= 1'b0;
                    deb_cnt_reg <= '0;
                    count_reg   <= '0;
                    pulse_reg   <= 1'b0;
                    limit_reg   <= 1'b0;
                end else begin
                    sync1_reg <= press[gi];
                    sync_reg  <= sync1_reg;
                    if (sync_reg == level_reg) begin
                        deb_cnt_reg <= '0;
                    end else if (accept) begin
                        level_reg   <= sync_reg;
                        deb_cnt_reg <= '0;
                    end else begin
                        deb_cnt_reg <= deb_cnt_reg + DEB_W'(1);
                    end
                    pulse_reg <= event_hit;
                    count_reg <= count_next;
                    limit_reg <= limit_next;
                end
            end

            assign count[gi*CNT_W +: CNT_W] = count_reg;
            assign press_pulse[gi]          = pulse_reg;
            assign limit[gi]                = limit_reg;
        end
    endgenerate

endmodule
